// File: rtl/down_counter_3bit_pkg.sv
// Shared counter constants, common to the up- and down-counters so both
// agree on width, reset value and all-ones value.
package down_counter_3bit_pkg;

   localparam int          CNT_WIDTH   = 3;
   localparam logic [2:0]  CNT_RST_VAL = 3'b000;
   localparam logic [2:0]  CNT_MAX     = 3'b111;

endpackage : down_counter_3bit_pkg

// File: rtl/down_counter_3bit_full_subtractor.sv
// One-bit gate-level full subtractor: diff = a - b - bin, bout on borrow.
// XOR is built in two stages from not/and/or, mirroring the adder cell.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic a_n, b_n, bin_n;
   logic x1, x1_n, x1_t0, x1_t1;
   logic d_t0, d_t1;
   logic bo_t0, bo_t1, bo_t2;

   not u_not_a   (a_n, a);
   not u_not_b   (b_n, b);
   not u_not_bin (bin_n, bin);

   // first XOR stage: a ^ b
   and u_and_x0 (x1_t0, a, b_n);
   and u_and_x1 (x1_t1, a_n, b);
   or  u_or_x   (x1, x1_t0, x1_t1);
   not u_not_x1 (x1_n, x1);

   // second XOR stage: (a ^ b) ^ bin
   and u_and_d0 (d_t0, x1, bin_n);
   and u_and_d1 (d_t1, x1_n, bin);
   or  u_or_d   (diff, d_t0, d_t1);

   // borrow-out: (~a & b) | (~a & bin) | (b & bin)
   and u_and_b0 (bo_t0, a_n, b);
   and u_and_b1 (bo_t1, a_n, bin);
   and u_and_b2 (bo_t2, b, bin);
   or  u_or_bo  (bout, bo_t0, bo_t1, bo_t2);

endmodule : full_subtractor

// File: rtl/down_counter_3bit.sv
// Loadable down-counter with zero flag and registered underflow pulse.
// Decrement comes from a ripple chain of full subtractors whose borrow-in
// at bit 0 is the enable, so the MSB borrow-out is the underflow attempt.
module down_counter_3bit
   import down_counter_3bit_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             uflow
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             uflow_q, uflow_d;
   logic [WIDTH-1:0] dec;
   logic [WIDTH:0]   borrow;
   logic [WIDTH-1:0] or_chain;
   logic             underflow;

   assign borrow[0] = en;

   for (genvar i = 0; i < WIDTH; i++) begin : g_sub
      full_subtractor u_fs (
         .a    (count_q[i]),
         .b    (1'b0),
         .bin  (borrow[i]),
         .diff (dec[i]),
         .bout (borrow[i+1])
      );
   end

   assign underflow = borrow[WIDTH];

   // zero detect as an OR chain followed by an inverter (a wide NOR)
   assign or_chain[0] = count_q[0];
   for (genvar i = 1; i < WIDTH; i++) begin : g_zero
      or u_or_z (or_chain[i], or_chain[i-1], count_q[i]);
   end
   not u_not_z (zero, or_chain[WIDTH-1]);

   // next-state selection: load beats enable; enable=0 makes dec == count_q
   always_comb begin
      count_d = count_q;
      uflow_d = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         uflow_d = underflow;
         if (underflow && !WRAP) begin
            count_d = count_q;
         end else begin
            count_d = dec;
         end
      end
   end

   // state register with synchronous reset taking precedence over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= WIDTH'(CNT_RST_VAL);
         uflow_q <= 1'b0;
      end else begin
         count_q <= count_d;
         uflow_q <= uflow_d;
      end
   end

   assign count = count_q;
   assign uflow = uflow_q;

endmodule : down_counter_3bit

// File: tb/tb_down_counter_3bit.sv
// Directed and randomized checks for down_counter_3bit in wrap and saturate
// modes, plus an exhaustive truth-table check of the subtractor cell.
module tb_down_counter_3bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       w_en, w_load;
   logic [2:0] w_load_val;
   logic [2:0] w_count;
   logic       w_zero, w_uflow;
   logic       s_en, s_load;
   logic [2:0] s_load_val;
   logic [2:0] s_count;
   logic       s_zero, s_uflow;
   logic       fa, fb, fbin, fdiff, fbout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   down_counter_3bit #(.WIDTH(3), .WRAP(1'b1)) u_dut_wrap (
      .clk(clk), .rst(rst), .en(w_en), .load(w_load), .load_val(w_load_val),
      .count(w_count), .zero(w_zero), .uflow(w_uflow)
   );

   down_counter_3bit #(.WIDTH(3), .WRAP(1'b0)) u_dut_sat (
      .clk(clk), .rst(rst), .en(s_en), .load(s_load), .load_val(s_load_val),
      .count(s_count), .zero(s_zero), .uflow(s_uflow)
   );

   full_subtractor u_fs (
      .a(fa), .b(fb), .bin(fbin), .diff(fdiff), .bout(fbout)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_w(input string tag, input int c, input int z, input int u);
      chk({tag, " count"}, w_count, c);
      chk({tag, " zero"},  w_zero,  z);
      chk({tag, " uflow"}, w_uflow, u);
   endtask

   initial begin
      logic [2:0] m_wc, m_sc;
      logic       m_wu, m_su;
      logic [1:0] res;
      int         exp_c [6];
      int         exp_z [6];
      int         exp_u [6];
      int         sat_c [4];
      int         sat_u [4];

      rst = 1'b1; w_en = 1'b1; w_load = 1'b1; w_load_val = 3'd5;
      s_en = 1'b1; s_load = 1'b1; s_load_val = 3'd5;
      fa = 1'b0; fb = 1'b0; fbin = 1'b0;

      // reset dominates load and enable
      step(); step();
      chk_w("reset", 0, 1, 0);
      chk("reset sat count", s_count, 0);

      // first enabled edge after reset wraps
      rst = 1'b0; w_load = 1'b0; s_load = 1'b0; s_en = 1'b0;
      step();
      chk_w("first wrap", 7, 0, 1);

      // load 5 then count down through the wrap
      w_load = 1'b1; w_en = 1'b0;
      step();
      chk_w("load5", 5, 0, 0);
      w_load = 1'b0; w_en = 1'b1;
      exp_c = '{4, 3, 2, 1, 0, 7};
      exp_z = '{0, 0, 0, 0, 1, 0};
      exp_u = '{0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 6; i++) begin
         step();
         chk_w($sformatf("count%0d", i), exp_c[i], exp_z[i], exp_u[i]);
      end

      // load wins over enable
      w_load = 1'b1; w_load_val = 3'd3;
      step();
      chk_w("prio load3", 3, 0, 0);
      w_load_val = 3'd0;
      step();
      chk_w("load0", 0, 1, 0);
      step();
      chk_w("prio load0 at zero", 0, 1, 0);

      // hold with load_val wiggling
      w_load_val = 3'd4;
      step();
      w_load = 1'b0; w_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w_load_val = 3'(i + 1);
         step();
         chk_w($sformatf("hold%0d", i), 4, 0, 0);
      end

      // saturate mode
      s_load = 1'b1; s_load_val = 3'd1; s_en = 1'b0;
      step();
      chk("sat load1", s_count, 1);
      s_load = 1'b0; s_en = 1'b1;
      sat_c = '{0, 0, 0, 0};
      sat_u = '{0, 1, 1, 1};
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("sat%0d count", i), s_count, sat_c[i]);
         chk($sformatf("sat%0d uflow", i), s_uflow, sat_u[i]);
         chk($sformatf("sat%0d zero", i),  s_zero,  1);
      end

      // subtractor truth table
      for (int i = 0; i < 8; i++) begin
         {fa, fb, fbin} = 3'(i);
         #1;
         res = {1'b0, fa} - {1'b0, fb} - {1'b0, fbin};
         chk($sformatf("fs%0d diff", i), fdiff, res[0]);
         chk($sformatf("fs%0d bout", i), fbout, res[1]);
      end

      // random stream against a behavioral reference
      m_wc = w_count; m_wu = w_uflow;
      m_sc = s_count; m_su = s_uflow;
      for (int n = 0; n < 1000; n++) begin
         rst        = ($urandom_range(0, 49) == 0);
         w_en       = $urandom_range(0, 3) != 0;
         w_load     = ($urandom_range(0, 7) == 0);
         w_load_val = 3'($urandom_range(0, 7));
         s_en       = $urandom_range(0, 3) != 0;
         s_load     = ($urandom_range(0, 7) == 0);
         s_load_val = 3'($urandom_range(0, 7));
         if (rst) begin
            m_wc = 3'd0; m_wu = 1'b0;
         end else if (w_load) begin
            m_wc = w_load_val; m_wu = 1'b0;
         end else if (w_en) begin
            m_wu = (m_wc == 3'd0);
            m_wc = m_wc - 3'd1;
         end else begin
            m_wu = 1'b0;
         end
         if (rst) begin
            m_sc = 3'd0; m_su = 1'b0;
         end else if (s_load) begin
            m_sc = s_load_val; m_su = 1'b0;
         end else if (s_en) begin
            m_su = (m_sc == 3'd0);
            if (m_sc != 3'd0) m_sc = m_sc - 3'd1;
         end else begin
            m_su = 1'b0;
         end
         step();
         chk("rnd wrap count", w_count, m_wc);
         chk("rnd wrap zero",  w_zero,  (m_wc == 3'd0));
         chk("rnd wrap uflow", w_uflow, m_wu);
         chk("rnd sat count",  s_count, m_sc);
         chk("rnd sat zero",   s_zero,  (m_sc == 3'd0));
         chk("rnd sat uflow",  s_uflow, m_su);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_down_counter_3bit
